// File: rtl/sram_access_arbiter.sv
// ============================================================================
// sram_access_arbiter: round-robin two-port arbiter and fixed-timing sequencer
// for a single-port asynchronous SRAM.            Revision: 1.0
// ============================================================================
`default_nettype none

module sram_access_arbiter #(
  parameter int ADDR_W        = 11,
  parameter int DATA_W        = 8,
  parameter int STROBE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_doe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int c_cnt_w = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(STROBE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                port_q, port_d;       // 0 = A, 1 = B
  logic                last_q, last_d;       // last granted port
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                doe_q, doe_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;

  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  // A wins unless B is also requesting and A was served last.
  assign w_grant_a   = a_req && (!b_req || last_q);
  assign w_grant_b   = b_req && !w_grant_a;
  assign w_sel_we    = w_grant_b ? b_we    : a_we;
  assign w_sel_addr  = w_grant_b ? b_addr  : a_addr;
  assign w_sel_wdata = w_grant_b ? b_wdata : a_wdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    port_d  = port_q;
    last_d  = last_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    doe_d   = doe_q;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          state_d = SETUP;
          port_d  = w_grant_b;
          last_d  = w_grant_b;
          we_d    = w_sel_we;
          addr_d  = w_sel_addr;
          dout_d  = w_sel_wdata;
          ce_n_d  = 1'b0;
          doe_d   = w_sel_we;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = c_cnt_load;
        oe_n_d  = we_q;
        we_n_d  = !we_q;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          a_ack_d = !port_q;
          b_ack_d = port_q;
          if (!we_q) begin
            rdata_d = sram_din;
          end
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      HOLD: begin
        // Releasing ce_n and the driver here guarantees a turnaround cycle.
        state_d = IDLE;
        ce_n_d  = 1'b1;
        doe_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      port_q  <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      doe_q   <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      port_q  <= port_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      doe_q   <= doe_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign rdata     = rdata_q;
  assign sram_addr = addr_q;
  assign sram_dout = dout_q;
  assign sram_doe  = doe_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;

endmodule

`default_nettype wire
